rete_lut_sincronizzata: RTL and testbench



---
 rtl/rete_lut_pkg.sv | 16 +
 rtl/rete_lut_mem.sv | 54 +++++
 rtl/rete_lut_sincronizzata.sv | 105 ++++++++++
 tb/tb_rete_lut_sincronizzata.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rete_lut_pkg.sv
// Shared types and constants for the registered truth-table network.
package rete_lut_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned N_IN_DEF  = 3;
  localparam int unsigned N_OUT_DEF = 2;

  function automatic int unsigned DEPTH(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/rete_lut_mem.sv
// DEPTH x N_OUT register table: one write port, registered lookup port and,
// with RETE_LUT_READBACK_EN, a second registered read port.
module rete_lut_mem
  import rete_lut_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic             re,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata
`ifdef RETE_LUT_READBACK_EN
  ,
  input  logic             rb_clr,
  input  logic [N_IN-1:0]  rb_addr,
  output logic [N_OUT-1:0] rb_data
`endif
);

  localparam int unsigned TABLE_DEPTH = DEPTH(N_IN);

  logic [N_OUT-1:0] mem [TABLE_DEPTH];

  // Reads sample the pre-write contents, giving read-before-write on collision.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

`ifdef RETE_LUT_READBACK_EN
  always_ff @(posedge clock) begin
    if (reset || rb_clr) begin
      rb_data <= '0;
    end else begin
      rb_data <= mem[rb_addr];
    end
  end
`endif

endmodule

// File: rtl/rete_lut_sincronizzata.sv
// Programmable registered truth-table network with valid/ready lookup, write
// port and post-reset default sweep. Optional readback port: RETE_LUT_READBACK_EN.
module rete_lut_sincronizzata
  import rete_lut_pkg::*;
#(
  parameter int unsigned          N_IN        = N_IN_DEF,
  parameter int unsigned          N_OUT       = N_OUT_DEF,
  parameter logic [N_OUT-1:0]     DEFAULT_OUT = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_x,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_z,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             wr_en,
  input  logic [N_IN-1:0]  wr_addr,
  input  logic [N_OUT-1:0] wr_data,
  output logic             wr_ready,
  output logic             busy
`ifdef RETE_LUT_READBACK_EN
  ,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data
`endif
);

  localparam int unsigned   TABLE_DEPTH = DEPTH(N_IN);
  localparam logic [N_IN:0] SWEEP_LAST  = (N_IN + 1)'(TABLE_DEPTH - 1);

  state_t           state;
  logic [N_IN:0]    cnt;
  logic             accept;
  logic             mem_we;
  logic [N_IN-1:0]  mem_waddr;
  logic [N_OUT-1:0] mem_wdata;

  assign busy     = (state == INIT);
  assign wr_ready = (state == RUN);
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !reset;

  // The sweep owns the write port during INIT; external writes only in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt[N_IN-1:0];
        mem_wdata = DEFAULT_OUT;
      end else begin
        mem_we = wr_en;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == SWEEP_LAST) begin
            state <= RUN;
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
      if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  rete_lut_mem #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .re      (accept),
    .raddr   (in_x),
    .rdata   (out_z)
`ifdef RETE_LUT_READBACK_EN
    ,
    .rb_clr  (state != RUN),
    .rb_addr (rd_addr),
    .rb_data (rd_data)
`endif
  );

endmodule

// File: tb/tb_rete_lut_sincronizzata.sv
// Directed self-checking bench for rete_lut_sincronizzata (default parameters).
module tb_rete_lut_sincronizzata;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] in_x;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_z;
  logic       out_valid;
  logic       out_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_ready;
  logic       busy;
`ifdef RETE_LUT_READBACK_EN
  logic [2:0] rd_addr;
  logic [1:0] rd_data;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] x;
    logic [1:0] z;
  } vec_t;

  vec_t prog_tbl [8];

  always #5 clock = ~clock;

  rete_lut_sincronizzata #(
    .N_IN        (3),
    .N_OUT       (2),
    .DEFAULT_OUT (2'b00)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_x      (in_x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_z     (out_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy)
`ifdef RETE_LUT_READBACK_EN
    ,
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic lookup(input logic [2:0] a);
    in_x      = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Counts post-edge samples with busy high, starting at the reset-edge sample.
  task automatic wait_sweep(input bit wr_during, output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      if (wr_during) begin
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 2'b11;
        check("wr_ready_init", 32'(wr_ready), 32'd0);
      end
      n++;
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    prog_tbl[0] = '{x: 3'd0, z: 2'b00};
    prog_tbl[1] = '{x: 3'd1, z: 2'b01};
    prog_tbl[2] = '{x: 3'd2, z: 2'b10};
    prog_tbl[3] = '{x: 3'd3, z: 2'b10};
    prog_tbl[4] = '{x: 3'd4, z: 2'b11};
    prog_tbl[5] = '{x: 3'd5, z: 2'b11};
    prog_tbl[6] = '{x: 3'd6, z: 2'b00};
    prog_tbl[7] = '{x: 3'd7, z: 2'b00};

    reset = 1'b1; in_x = '0; in_valid = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef RETE_LUT_READBACK_EN
    rd_addr = '0;
`endif
    step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    wait_sweep(1'b0, n);
    check("sweep_len", 32'(n), 32'd8);
    check("run_in_ready", 32'(in_ready), 32'd1);
    check("run_wr_ready", 32'(wr_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      lookup(3'(i));
      check("default_valid", 32'(out_valid), 32'd1);
      check("default_z", 32'(out_z), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      if (prog_tbl[i].z != 2'b00) wr(prog_tbl[i].x, prog_tbl[i].z);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_x     = prog_tbl[i].x;
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_z", 32'(out_z), 32'(prog_tbl[i].z));
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    lookup(3'd4);
    check("hold_pre_z", 32'(out_z), 32'd3);
    step();
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_z", 32'(out_z), 32'd3);

    in_x = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("bp_first_ready", 32'(in_ready), 32'd1);
    step();
    in_x = 3'd1;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_z", 32'(out_z), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    check("bp_z_after", 32'(out_z), 32'd3);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd1);
    check("bp_release_z", 32'(out_z), 32'd1);

    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 2'b01;
    in_x = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    wr_en = 1'b0; in_valid = 1'b0;
    check("rbw_old", 32'(out_z), 32'd2);
    lookup(3'd2);
    check("rbw_new", 32'(out_z), 32'd1);

`ifdef RETE_LUT_READBACK_EN
    rd_addr = 3'd4;
    step();
    check("readback_4", 32'(rd_data), 32'd3);
`endif

    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("mid_sweep_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
`ifdef RETE_LUT_READBACK_EN
    check("readback_init_zero", 32'(rd_data), 32'd0);
`endif
    wait_sweep(1'b1, n);
    check("mid_sweep_len", 32'(n), 32'd8);
    lookup(3'd6);
    check("init_write_dropped", 32'(out_z), 32'd0);
    lookup(3'd3);
    check("sweep_cleared_3", 32'(out_z), 32'd0);

    wr(3'd4, 2'b11);
    in_x = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("run_rst_pre_valid", 32'(out_valid), 32'd1);
    check("run_rst_pre_z", 32'(out_z), 32'd3);
    reset = 1'b1;
    step();
    check("run_rst_valid", 32'(out_valid), 32'd0);
    check("run_rst_z", 32'(out_z), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    wait_sweep(1'b0, n);
    check("run_rst_sweep_len", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      lookup(3'(i));
      check("post_rst_z", 32'(out_z), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
